// File: rtl/rect_update_sequencer_if.sv
// Random-source handshake between the rectangle sequencer (master) and the
// shared random word generator (slave).
interface rect_update_sequencer_if;
  logic       rnd_req;
  logic       rnd_vld;
  logic [9:0] rnd_data;

  modport master (output rnd_req, input rnd_vld, input rnd_data);
  modport slave  (input rnd_req, output rnd_vld, output rnd_data);
endinterface

// File: rtl/rect_update_sequencer.sv
// Once-per-second rectangle refresh: fetch eight random words, fold them into
// screen range, order each edge pair, and commit all eight at end of frame.
module rect_update_sequencer #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sec_pre,
  input  logic                          frame_end,
  rect_update_sequencer_if.master       rnd,
  output logic [9:0]                    rw0_out,
  output logic [9:0]                    rw1_out,
  output logic [8:0]                    rh0_out,
  output logic [8:0]                    rh1_out,
  output logic [9:0]                    bw0_out,
  output logic [9:0]                    bw1_out,
  output logic [8:0]                    bh0_out,
  output logic [8:0]                    bh1_out,
  output logic                          busy,
  output logic                          upd_done,
  output logic                          ovr
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_ORDER      = 3'd2,
    S_WAIT_FRAME = 3'd3,
    S_COMMIT     = 3'd4
  } state_t;

  localparam logic [9:0] W_ACT  = 10'(H_ACT);
  localparam logic [8:0] H_ACTV = 9'(V_ACT);
  localparam logic [9:0] W_HALF = 10'(H_ACT / 2);
  localparam logic [8:0] H_HALF = 9'(V_ACT / 2);

  state_t          state_q, state_d;
  logic [2:0]      slot_q, slot_d;
  // Index 0..3 = rw0, rw1, bw0, bw1 and rh0, rh1, bh0, bh1 respectively.
  logic [3:0][9:0] shw_q, shw_d;
  logic [3:0][8:0] shh_q, shh_d;
  logic [3:0][9:0] ow_q;
  logic [3:0][8:0] oh_q;
  logic            busy_q, upd_done_q, ovr_q;
  logic [9:0]      red_w_s;
  logic [8:0]      raw_h_s, red_h_s;

  // Next-state logic for the refresh sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sec_pre) state_d = S_FETCH;
        else         state_d = S_IDLE;
      end
      S_FETCH: begin
        if (rnd.rnd_vld && (slot_q == 3'd7)) state_d = S_ORDER;
        else                                 state_d = S_FETCH;
      end
      S_ORDER: state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (frame_end) state_d = S_COMMIT;
        else           state_d = S_WAIT_FRAME;
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Fold a raw word into screen range with one conditional subtract.
  always_comb begin
    raw_h_s = rnd.rnd_data[8:0];
    if (rnd.rnd_data >= W_ACT) red_w_s = rnd.rnd_data - W_ACT;
    else                       red_w_s = rnd.rnd_data;
    if (raw_h_s >= H_ACTV) red_h_s = raw_h_s - H_ACTV;
    else                   red_h_s = raw_h_s;
  end

  // Shadow capture during FETCH and pair ordering during ORDER.
  always_comb begin
    shw_d  = shw_q;
    shh_d  = shh_q;
    slot_d = slot_q;
    case (state_q)
      S_IDLE: begin
        if (sec_pre) slot_d = 3'd0;
        else         slot_d = slot_q;
      end
      S_FETCH: begin
        if (rnd.rnd_vld) begin
          slot_d = slot_q + 3'd1;
          // Slots with bit1 clear are widths; {bit2,bit0} picks the pair entry.
          if (slot_q[1] == 1'b0) shw_d[{slot_q[2], slot_q[0]}] = red_w_s;
          else                   shh_d[{slot_q[2], slot_q[0]}] = red_h_s;
        end else begin
          slot_d = slot_q;
        end
      end
      S_ORDER: begin
        for (int p = 0; p < 2; p++) begin
          if (shw_q[2*p] > shw_q[2*p+1]) begin
            shw_d[2*p]   = shw_q[2*p+1];
            shw_d[2*p+1] = shw_q[2*p];
          end else begin
            shw_d[2*p]   = shw_q[2*p];
          end
          if (shh_q[2*p] > shh_q[2*p+1]) begin
            shh_d[2*p]   = shh_q[2*p+1];
            shh_d[2*p+1] = shh_q[2*p];
          end else begin
            shh_d[2*p]   = shh_q[2*p];
          end
        end
      end
      default: slot_d = slot_q;
    endcase
  end

  // State, slot index and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      slot_q  <= 3'd0;
      shw_q   <= '0;
      shh_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      shw_q   <= shw_d;
      shh_q   <= shh_d;
    end
  end

  // Displayed coordinates change only on the COMMIT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ow_q[0] <= 10'd0;
      ow_q[1] <= W_HALF - 10'd1;
      ow_q[2] <= W_HALF;
      ow_q[3] <= W_ACT - 10'd1;
      oh_q[0] <= 9'd0;
      oh_q[1] <= H_HALF - 9'd1;
      oh_q[2] <= H_HALF;
      oh_q[3] <= H_ACTV - 9'd1;
    end else if (state_q == S_COMMIT) begin
      ow_q <= shw_q;
      oh_q <= shh_q;
    end else begin
      ow_q <= ow_q;
      oh_q <= oh_q;
    end
  end

  // Status flags, registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      upd_done_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      busy_q     <= (state_d != S_IDLE);
      upd_done_q <= (state_d == S_COMMIT);
      if (sec_pre && (state_q != S_IDLE)) ovr_q <= 1'b1;
      else                                ovr_q <= ovr_q;
    end
  end

  assign rnd.rnd_req = (state_q == S_FETCH);
  assign rw0_out  = ow_q[0];
  assign rw1_out  = ow_q[1];
  assign bw0_out  = ow_q[2];
  assign bw1_out  = ow_q[3];
  assign rh0_out  = oh_q[0];
  assign rh1_out  = oh_q[1];
  assign bh0_out  = oh_q[2];
  assign bh1_out  = oh_q[3];
  assign busy     = busy_q;
  assign upd_done = upd_done_q;
  assign ovr      = ovr_q;

endmodule

// File: tb/tb_rect_update_sequencer.sv
// Directed bench for rect_update_sequencer with a cycle-level reference model.
module tb_rect_update_sequencer;
  logic clk, rst, sec_pre, frame_end;
  logic [9:0] rw0, rw1, bw0, bw1;
  logic [8:0] rh0, rh1, bh0, bh1;
  logic busy, upd_done, ovr;

  rect_update_sequencer_if rif ();

  rect_update_sequencer #(.H_ACT(640), .V_ACT(480)) dut (
    .clk(clk), .rst(rst), .sec_pre(sec_pre), .frame_end(frame_end), .rnd(rif),
    .rw0_out(rw0), .rw1_out(rw1), .rh0_out(rh0), .rh1_out(rh1),
    .bw0_out(bw0), .bw1_out(bw1), .bh0_out(bh0), .bh1_out(bh1),
    .busy(busy), .upd_done(upd_done), .ovr(ovr)
  );

  int vec = 0;
  int err = 0;
  int upd_cnt = 0;
  int cap_cnt = 0;
  logic [9:0] wv [8];

  // Reference model: phase 0 idle, 1 fetch, 2 order, 3 wait, 4 commit.
  int m_phase;
  int m_q[$];
  int m_w[4];
  int m_h[4];
  bit m_ovr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int redw(input int x);
    return x % 640;
  endfunction

  function automatic int redh(input int x);
    return (x % 512) % 480;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a < b) ? b : a;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_q.delete();
    m_ovr = 1'b0;
    m_w[0] = 0;   m_w[1] = 319; m_w[2] = 320; m_w[3] = 639;
    m_h[0] = 0;   m_h[1] = 239; m_h[2] = 240; m_h[3] = 479;
  endtask

  task automatic model_commit();
    m_w[0] = imin(redw(m_q[0]), redw(m_q[1]));
    m_w[1] = imax(redw(m_q[0]), redw(m_q[1]));
    m_h[0] = imin(redh(m_q[2]), redh(m_q[3]));
    m_h[1] = imax(redh(m_q[2]), redh(m_q[3]));
    m_w[2] = imin(redw(m_q[4]), redw(m_q[5]));
    m_w[3] = imax(redw(m_q[4]), redw(m_q[5]));
    m_h[2] = imin(redh(m_q[6]), redh(m_q[7]));
    m_h[3] = imax(redh(m_q[6]), redh(m_q[7]));
  endtask

  // Mid-cycle: compare DUT against model, then advance model with the inputs
  // the DUT will sample at the coming rising edge.
  always @(negedge clk) begin
    if (rst) model_reset();
    chk("rnd_req", int'(rif.rnd_req), int'(m_phase == 1));
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("upd_done", int'(upd_done), int'(m_phase == 4));
    chk("ovr", int'(ovr), int'(m_ovr));
    chk("rw0", int'(rw0), m_w[0]);
    chk("rw1", int'(rw1), m_w[1]);
    chk("bw0", int'(bw0), m_w[2]);
    chk("bw1", int'(bw1), m_w[3]);
    chk("rh0", int'(rh0), m_h[0]);
    chk("rh1", int'(rh1), m_h[1]);
    chk("bh0", int'(bh0), m_h[2]);
    chk("bh1", int'(bh1), m_h[3]);
    if (upd_done) upd_cnt++;
    if (rif.rnd_req && rif.rnd_vld) cap_cnt++;
    if (!rst) begin
      if (sec_pre && m_phase != 0) m_ovr = 1'b1;
      case (m_phase)
        0: if (sec_pre) begin m_phase = 1; m_q.delete(); end
        1: if (rif.rnd_vld) begin
             m_q.push_back(int'(rif.rnd_data));
             if (m_q.size() == 8) m_phase = 2;
           end
        2: m_phase = 3;
        3: if (frame_end) m_phase = 4;
        default: begin model_commit(); m_phase = 0; end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sec();
    sec_pre = 1'b1;
    tick();
    sec_pre = 1'b0;
  endtask

  // Feed nw words from wv; mode 1 toggles rnd_vld 1,0,0,...; frame_end at cycle fe_at.
  task automatic fetch(input int nw, input int mode, input int fe_at);
    int idx = 0;
    int cyc = 0;
    bit cap;
    while (idx < nw && cyc < 200) begin
      rif.rnd_vld  = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      rif.rnd_data = wv[idx];
      frame_end    = (cyc == fe_at);
      cap = rif.rnd_req && rif.rnd_vld;
      tick();
      if (cap) idx++;
      cyc++;
    end
    rif.rnd_vld = 1'b0;
    frame_end   = 1'b0;
    if (idx < nw) chk("fetch_timeout", idx, nw);
  endtask

  task automatic commit_frame(input int old_rw1, input int new_rw1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("upd_done_at_F", int'(upd_done), 1);
    chk("rw1_held_at_F", int'(rw1), old_rw1);
    tick();
    chk("rw1_new_at_F1", int'(rw1), new_rw1);
    chk("upd_done_clear", int'(upd_done), 0);
  endtask

  task automatic chk_outs(input int a, b, c, d, e, f, g, h);
    chk("lit_rw0", int'(rw0), a); chk("lit_rw1", int'(rw1), b);
    chk("lit_rh0", int'(rh0), c); chk("lit_rh1", int'(rh1), d);
    chk("lit_bw0", int'(bw0), e); chk("lit_bw1", int'(bw1), f);
    chk("lit_bh0", int'(bh0), g); chk("lit_bh1", int'(bh1), h);
  endtask

  initial begin
    rst = 1'b0; sec_pre = 1'b0; frame_end = 1'b0;
    rif.rnd_vld = 1'b0; rif.rnd_data = 10'd0;
    #2 rst = 1'b1;
    #1;
    chk_outs(0, 319, 0, 239, 320, 639, 240, 479);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(ovr), 0);
    chk("rst_req", int'(rif.rnd_req), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full update with range folding and equal/swap pairs.
    wv = '{10'd700, 10'd100, 10'd500, 10'd20, 10'd639, 10'd640, 10'd479, 10'd480};
    upd_cnt = 0;
    pulse_sec();
    fetch(8, 0, -1);
    tick();
    commit_frame(319, 100);
    chk_outs(60, 100, 20, 20, 0, 639, 0, 479);
    repeat (4) tick();
    chk("upd_once", upd_cnt, 1);

    // Stalled handshake.
    wv = '{10'd1023, 10'd5, 10'd511, 10'd479, 10'd300, 10'd200, 10'd0, 10'd481};
    cap_cnt = 0;
    pulse_sec();
    fetch(8, 1, -1);
    tick();
    chk("stall_caps", cap_cnt, 8);
    commit_frame(100, 383);
    chk_outs(5, 383, 31, 479, 200, 300, 0, 1);
    tick();

    // frame_end during FETCH is ignored; commit waits 50 cycles.
    wv = '{10'd639, 10'd0, 10'd0, 10'd479, 10'd320, 10'd320, 10'd240, 10'd240};
    pulse_sec();
    fetch(8, 0, 2);
    tick();
    repeat (50) tick();
    chk("wait_busy", int'(busy), 1);
    chk("wait_rw1_old", int'(rw1), 383);
    commit_frame(383, 639);
    chk_outs(0, 639, 0, 479, 320, 320, 240, 240);
    tick();

    // Overrun: sec_pre while waiting for the frame.
    wv = '{10'd100, 10'd50, 10'd200, 10'd100, 10'd400, 10'd300, 10'd450, 10'd400};
    pulse_sec();
    fetch(8, 0, -1);
    tick();
    pulse_sec();
    chk("ovr_set", int'(ovr), 1);
    repeat (3) tick();
    chk("ovr_no_fetch", int'(rif.rnd_req), 0);
    commit_frame(639, 100);
    chk_outs(50, 100, 100, 200, 300, 400, 400, 450);
    tick();
    chk("ovr_idle_busy", int'(busy), 0);
    chk("ovr_sticky", int'(ovr), 1);

    // Reset after four captures, then a fresh update from slot 0.
    wv = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60, 10'd70, 10'd80};
    pulse_sec();
    fetch(4, 0, -1);
    #1 rst = 1'b1;
    #1;
    chk_outs(0, 319, 0, 239, 320, 639, 240, 479);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_req", int'(rif.rnd_req), 0);
    chk("mid_rst_ovr", int'(ovr), 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_sec();
    fetch(8, 0, -1);
    tick();
    commit_frame(319, 20);
    chk_outs(10, 20, 30, 40, 50, 60, 70, 80);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
